// File: rtl/apb2nmi_if.sv
// apb2nmi_if: APB completer bus plus NMI master bus of the apb2nmi bridge
//   slave  modport: bridge view (APB inputs, NMI request outputs)
//   master modport: environment view (drives APB and NMI responses)
interface apb2nmi_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, mem_ready_i, mem_rdata_i,
    output pready_o, prdata_o, pslverr_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, mem_ready_i, mem_rdata_i,
    input  pready_o, prdata_o, pslverr_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/apb2nmi.sv
// apb2nmi: APB completer forwarding each transfer as one timed-out NMI request
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : apb2nmi_if.slave (APB psel/penable/pwrite/paddr/pwdata/pstrb -> pready/prdata/pslverr,
//            NMI mem_valid/mem_addr/mem_wdata/mem_wstrb -> mem_ready/mem_rdata)
module apb2nmi #(
  parameter int TIMEOUT = 255
) (
  input logic       clk_i,
  input logic       rst_ni,
  apb2nmi_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, valid_q, valid_d, ready_q, ready_d, expire;
  logic [31:0]   prdata_q, prdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  assign bus.pready_o    = ready_q;
  assign bus.pslverr_o   = err_q;
  assign bus.prdata_o    = prdata_q;
  assign bus.mem_valid_o = valid_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wstrb_o = wstrb_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    err_d    = 1'b0;
    valid_d  = 1'b0;
    ready_d  = 1'b0;
    expire   = (TIMEOUT != 0) && (cnt_q == LAST);
    case (state_q)
      IDLE: if (bus.psel_i) begin
        addr_d  = bus.paddr_i;
        wdata_d = bus.pwdata_i;
        wstrb_d = bus.pwrite_i ? bus.pstrb_i : 4'b0;
        cnt_d   = '0;
        valid_d = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        valid_d = 1'b1;
        // a response arriving on the expiry cycle still counts as success
        if (bus.mem_ready_i) begin
          prdata_d = (wstrb_q == 4'b0) ? bus.mem_rdata_i : 32'b0;
          valid_d  = 1'b0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else if (expire) begin
          prdata_d = 32'b0;
          err_d    = 1'b1;
          valid_d  = 1'b0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      prdata_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      prdata_q <= prdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end
endmodule

// File: tb/tb_apb2nmi.sv
// tb_apb2nmi: timeline-model bench for apb2nmi with directed transfers
module tb_apb2nmi;
  localparam int TO = 4;
  localparam int N  = 400;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  apb2nmi_if bus ();
  apb2nmi #(.TIMEOUT(TO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        ev [N];
  logic        ep [N];
  logic        ee [N];
  logic [31:0] ed [N];
  logic [31:0] ea [N];
  logic [31:0] ew [N];
  logic [3:0]  es [N];
  int n_cmp = 0, n_bad = 0, vcount = 0, last_rdy = -1;
  logic last_err = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cyc < N) begin
      chk("mem_valid", 32'(bus.mem_valid_o), 32'(ev[cyc]));
      chk("pready", 32'(bus.pready_o), 32'(ep[cyc]));
      chk("pslverr", 32'(bus.pslverr_o), 32'(ee[cyc]));
      chk("prdata", bus.prdata_o, ed[cyc]);
      chk("mem_addr", bus.mem_addr_o, ea[cyc]);
      chk("mem_wdata", bus.mem_wdata_o, ew[cyc]);
      chk("mem_wstrb", 32'(bus.mem_wstrb_o), 32'(es[cyc]));
    end
    if (bus.mem_valid_o) vcount++;
    if (bus.pready_o) begin
      last_rdy = cyc;
      last_err = bus.pslverr_o;
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Transfer whose setup is in the current cycle; w = wait cycles before mem_ready (w>=TO: never)
  task automatic plan(input bit wr, input logic [31:0] a, wd, rd, input logic [3:0] st,
                      input int w, output int d);
    int c = cyc;
    bit rdy = (w < TO);
    int n = rdy ? w + 1 : TO;
    logic [3:0] s = wr ? st : 4'h0;
    d = c + n + 1;
    for (int k = c + 1; k <= c + n; k++) ev[k] = 1'b1;
    ep[d] = 1'b1;
    ee[d] = !rdy;
    for (int k = d; k < N; k++) ed[k] = (rdy && s == 4'h0) ? rd : 32'h0;
    for (int k = c + 1; k < N; k++) begin
      ea[k] = a;
      ew[k] = wd;
      es[k] = s;
    end
  endtask
  task automatic setup(input bit wr, input logic [31:0] a, wd, rd, input logic [3:0] st);
    bus.psel_i = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i = wr;
    bus.paddr_i = a;
    bus.pwdata_i = wd;
    bus.pstrb_i = st;
    bus.mem_rdata_i = rd;
    bus.mem_ready_i = 1'b0;
  endtask
  task automatic xfer(input bit wr, input logic [31:0] a, wd, rd, input logic [3:0] st,
                      input int w, input bit drop, output int d, output int c0);
    c0 = cyc;
    plan(wr, a, wd, rd, st, w, d);
    setup(wr, a, wd, rd, st);
    step();
    bus.psel_i = !drop;
    bus.penable_i = !drop;
    for (int k = 0; k < d - c0 - 1; k++) begin
      bus.mem_ready_i = (k == w);
      step();
    end
    bus.mem_ready_i = 1'b0;
    step();
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
  endtask
  initial begin
    int d, c, d2, c2, v0;
    for (int k = 0; k < N; k++) begin
      ev[k] = 0; ep[k] = 0; ee[k] = 0; ed[k] = 0; ea[k] = 0; ew[k] = 0; es[k] = 0;
    end
    setup(1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    bus.psel_i = 1'b0;
    repeat (3) step();
    chk("reset_valid", 32'(bus.mem_valid_o), 32'h0);
    chk("reset_pready", 32'(bus.pready_o), 32'h0);
    chk("reset_addr", bus.mem_addr_o, 32'h0);
    rst_n = 1'b1;
    step();
    v0 = vcount;
    xfer(1'b1, 32'h100, 32'hDEADBEEF, 32'hBAD0BAD0, 4'hF, 0, 1'b0, d, c);
    chk("wr_vcnt", 32'(vcount - v0), 32'd1);
    chk("wr_latency", 32'(last_rdy - c), 32'd2);
    chk("wr_err", 32'(last_err), 32'h0);
    chk("wr_strb", 32'(bus.mem_wstrb_o), 32'hF);
    v0 = vcount;
    xfer(1'b0, 32'h204, 32'h0, 32'h12345678, 4'h0, 3, 1'b0, d, c);
    chk("rd_vcnt", 32'(vcount - v0), 32'd4);
    chk("rd_latency", 32'(last_rdy - c), 32'd5);
    chk("rd_data", bus.prdata_o, 32'h12345678);
    v0 = vcount;
    xfer(1'b0, 32'h208, 32'h0, 32'h99999999, 4'h0, TO, 1'b0, d, c);
    chk("to_vcnt", 32'(vcount - v0), 32'd4);
    chk("to_latency", 32'(last_rdy - c), 32'd5);
    chk("to_err", 32'(last_err), 32'h1);
    chk("to_data", bus.prdata_o, 32'h0);
    v0 = vcount;
    xfer(1'b1, 32'h10, 32'hA5A5A5A5, 32'h0, 4'h3, 1, 1'b0, d, c);
    xfer(1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 4'h0, 0, 1'b0, d2, c2);
    chk("b2b_start", 32'(c2 - d), 32'd1);
    chk("b2b_vcnt", 32'(vcount - v0), 32'd3);
    chk("b2b_data", bus.prdata_o, 32'hCAFEF00D);
    c = cyc;
    plan(1'b0, 32'h200, 32'h0, 32'h0, 4'h0, TO, d);
    setup(1'b0, 32'h200, 32'h0, 32'h0, 4'h0);
    step();
    bus.penable_i = 1'b1;
    step();
    #1 rst_n = 1'b0;
    for (int k = cyc; k < N; k++) begin
      ev[k] = 0; ep[k] = 0; ee[k] = 0; ed[k] = 0; ea[k] = 0; ew[k] = 0; es[k] = 0;
    end
    #1;
    chk("rst_mid_valid", 32'(bus.mem_valid_o), 32'h0);
    chk("rst_mid_pready", 32'(bus.pready_o), 32'h0);
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    xfer(1'b0, 32'h300, 32'h0, 32'h0BADCAFE, 4'h0, 2, 1'b0, d, c);
    chk("post_rst_data", bus.prdata_o, 32'h0BADCAFE);
    xfer(1'b0, 32'h304, 32'h11111111, 32'h44444444, 4'hF, 0, 1'b0, d, c);
    chk("rd_strb_ignored", 32'(bus.mem_wstrb_o), 32'h0);
    xfer(1'b1, 32'h308, 32'h22222222, 32'h55AA55AA, 4'h0, 0, 1'b0, d, c);
    chk("wr_nostrb_data", bus.prdata_o, 32'h55AA55AA);
    xfer(1'b0, 32'h30C, 32'h0, 32'h00000077, 4'h0, 1, 1'b1, d, c);
    chk("drop_latency", 32'(last_rdy - c), 32'd3);
    v0 = vcount;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hFFFFFFFF;
    repeat (2) step();
    bus.mem_ready_i = 1'b0;
    repeat (2) step();
    chk("idle_ready_vcnt", 32'(vcount - v0), 32'd0);
    chk("idle_ready_data", bus.prdata_o, 32'h00000077);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
